// File: rtl/id_stage_pipe_if.sv
// rtl/id_stage_pipe_if.sv - fetch, regfile, forwarding and EX bundle signals of the decode stage
interface id_stage_pipe_if #(
  parameter int DATA_W    = 32,
  parameter int FWD_DEPTH = 2,
  parameter int STALL_W   = 16
);
  logic                        in_valid;
  logic                        in_ready;
  logic [31:0]                 in_pc;
  logic [31:0]                 in_inst;
  logic                        rf_re1;
  logic                        rf_re2;
  logic [4:0]                  rf_raddr1;
  logic [4:0]                  rf_raddr2;
  logic [DATA_W-1:0]           rf_rdata1;
  logic [DATA_W-1:0]           rf_rdata2;
  logic [FWD_DEPTH-1:0]        fwd_we;
  logic [5*FWD_DEPTH-1:0]      fwd_waddr;
  logic [DATA_W*FWD_DEPTH-1:0] fwd_wdata;
  logic [FWD_DEPTH-1:0]        fwd_pend;
  logic                        out_valid;
  logic                        out_ready;
  logic [31:0]                 out_pc;
  logic [7:0]                  out_aluop;
  logic [2:0]                  out_alusel;
  logic [DATA_W-1:0]           out_src1;
  logic [DATA_W-1:0]           out_src2;
  logic [4:0]                  out_wd;
  logic                        out_wreg;
  logic                        out_invalid;
  logic [STALL_W-1:0]          stall_cnt;

  modport slave (
    input  in_valid, in_pc, in_inst, rf_rdata1, rf_rdata2,
           fwd_we, fwd_waddr, fwd_wdata, fwd_pend, out_ready,
    output in_ready, rf_re1, rf_re2, rf_raddr1, rf_raddr2,
           out_valid, out_pc, out_aluop, out_alusel, out_src1, out_src2,
           out_wd, out_wreg, out_invalid, stall_cnt
  );

  modport master (
    output in_valid, in_pc, in_inst, rf_rdata1, rf_rdata2,
           fwd_we, fwd_waddr, fwd_wdata, fwd_pend, out_ready,
    input  in_ready, rf_re1, rf_re2, rf_raddr1, rf_raddr2,
           out_valid, out_pc, out_aluop, out_alusel, out_src1, out_src2,
           out_wd, out_wreg, out_invalid, stall_cnt
  );
endinterface

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - registered MIPS decode stage with forwarding and load-use bubbles
module id_stage_pipe #(
  parameter int DATA_W    = 32,
  parameter int FWD_DEPTH = 2,
  parameter int STALL_W   = 16
) (
  input logic            clk,
  input logic            rst,
  id_stage_pipe_if.slave bus
);
  localparam logic [7:0] EXE_NOP_OP = 8'h00, EXE_AND_OP = 8'h24, EXE_OR_OP  = 8'h25,
                         EXE_XOR_OP = 8'h26, EXE_NOR_OP = 8'h27, EXE_SLL_OP = 8'h7C,
                         EXE_SRL_OP = 8'h02, EXE_SRA_OP = 8'h03;
  localparam logic [2:0] EXE_RES_NOP = 3'd0, EXE_RES_LOGIC = 3'd1, EXE_RES_SHIFT = 3'd2;

  logic [31:0]       inst;
  logic [5:0]        op, fn;
  logic [4:0]        rs, rt, rd, sa;
  logic [15:0]       imm;
  logic              re1, re2, wreg, invalid;
  logic [7:0]        aluop;
  logic [2:0]        alusel;
  logic [4:0]        wd;
  logic [DATA_W-1:0] imm1, imm2, src1, src2;
  logic [DATA_W:0]   res1, res2;
  logic              hazard, slot_free;

  assign inst = bus.in_inst;
  assign op   = inst[31:26];
  assign rs   = inst[25:21];
  assign rt   = inst[20:16];
  assign rd   = inst[15:11];
  assign sa   = inst[10:6];
  assign fn   = inst[5:0];
  assign imm  = inst[15:0];

  always_comb begin
    re1 = 1'b0; re2 = 1'b0; wreg = 1'b0; invalid = 1'b0; wd = 5'd0;
    aluop = EXE_NOP_OP; alusel = EXE_RES_NOP; imm1 = '0; imm2 = '0;
    if (inst != 32'd0) begin
      case (op)
        6'h00: begin
          case (fn)
            6'h24, 6'h25, 6'h26, 6'h27, 6'h04, 6'h06, 6'h07: begin
              if (sa == 5'd0) begin
                re1 = 1'b1; re2 = 1'b1; wd = rd; wreg = 1'b1;
                case (fn)
                  6'h24:   begin aluop = EXE_AND_OP; alusel = EXE_RES_LOGIC; end
                  6'h25:   begin aluop = EXE_OR_OP;  alusel = EXE_RES_LOGIC; end
                  6'h26:   begin aluop = EXE_XOR_OP; alusel = EXE_RES_LOGIC; end
                  6'h27:   begin aluop = EXE_NOR_OP; alusel = EXE_RES_LOGIC; end
                  6'h04:   begin aluop = EXE_SLL_OP; alusel = EXE_RES_SHIFT; end
                  6'h06:   begin aluop = EXE_SRL_OP; alusel = EXE_RES_SHIFT; end
                  default: begin aluop = EXE_SRA_OP; alusel = EXE_RES_SHIFT; end
                endcase
              end else begin
                invalid = 1'b1;
              end
            end
            6'h0F: invalid = (sa != 5'd0);
            6'h00, 6'h02, 6'h03: begin
              // Shift-imm carries the shamt as src1 so EX sees the same roles as SLLV
              if (inst[31:21] == 11'd0) begin
                re2 = 1'b1; wd = rd; wreg = 1'b1; alusel = EXE_RES_SHIFT;
                imm1 = DATA_W'(sa);
                case (fn)
                  6'h00:   aluop = EXE_SLL_OP;
                  6'h02:   aluop = EXE_SRL_OP;
                  default: aluop = EXE_SRA_OP;
                endcase
              end else begin
                invalid = 1'b1;
              end
            end
            default: invalid = 1'b1;
          endcase
        end
        6'h0D, 6'h0C, 6'h0E: begin
          re1 = 1'b1; wd = rt; wreg = 1'b1; alusel = EXE_RES_LOGIC;
          imm2 = DATA_W'(imm);
          case (op)
            6'h0D:   aluop = EXE_OR_OP;
            6'h0C:   aluop = EXE_AND_OP;
            default: aluop = EXE_XOR_OP;
          endcase
        end
        6'h0F: begin
          re1 = 1'b1; wd = rt; wreg = 1'b1; alusel = EXE_RES_LOGIC; aluop = EXE_OR_OP;
          imm2 = DATA_W'({imm, 16'h0000});
        end
        default: invalid = 1'b1;
      endcase
    end
  end

  // Returns {pending, data}; the nearest matching source wins even when a farther one is pending
  function automatic logic [DATA_W:0] resolve(
    input logic [4:0]                  addr,
    input logic [DATA_W-1:0]           rdata,
    input logic [FWD_DEPTH-1:0]        we,
    input logic [5*FWD_DEPTH-1:0]      waddr,
    input logic [DATA_W*FWD_DEPTH-1:0] wdata,
    input logic [FWD_DEPTH-1:0]        pend
  );
    logic [DATA_W:0] r;
    logic            found;
    r = {1'b0, rdata};
    found = 1'b0;
    if (addr == 5'd0) begin
      r = '0;
    end else begin
      for (int i = 0; i < FWD_DEPTH; i++) begin
        if (!found && we[i] && waddr[5*i +: 5] == addr) begin
          found = 1'b1;
          r = {pend[i], wdata[DATA_W*i +: DATA_W]};
        end
      end
    end
    return r;
  endfunction

  assign res1 = resolve(rs, bus.rf_rdata1, bus.fwd_we, bus.fwd_waddr, bus.fwd_wdata, bus.fwd_pend);
  assign res2 = resolve(rt, bus.rf_rdata2, bus.fwd_we, bus.fwd_waddr, bus.fwd_wdata, bus.fwd_pend);
  assign src1 = re1 ? res1[DATA_W-1:0] : imm1;
  assign src2 = re2 ? res2[DATA_W-1:0] : imm2;
  assign hazard    = (re1 && res1[DATA_W]) || (re2 && res2[DATA_W]);
  assign slot_free = !bus.out_valid || bus.out_ready;

  assign bus.in_ready  = slot_free && !hazard;
  assign bus.rf_re1    = re1;
  assign bus.rf_re2    = re2;
  assign bus.rf_raddr1 = rs;
  assign bus.rf_raddr2 = rt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_valid   <= 1'b0;
      bus.out_pc      <= '0;
      bus.out_aluop   <= EXE_NOP_OP;
      bus.out_alusel  <= EXE_RES_NOP;
      bus.out_src1    <= '0;
      bus.out_src2    <= '0;
      bus.out_wd      <= '0;
      bus.out_wreg    <= 1'b0;
      bus.out_invalid <= 1'b0;
      bus.stall_cnt   <= '0;
    end else if (slot_free) begin
      if (bus.in_valid && !hazard) begin
        bus.out_valid   <= 1'b1;
        bus.out_pc      <= bus.in_pc;
        bus.out_aluop   <= aluop;
        bus.out_alusel  <= alusel;
        bus.out_src1    <= src1;
        bus.out_src2    <= src2;
        bus.out_wd      <= wd;
        bus.out_wreg    <= wreg;
        bus.out_invalid <= invalid;
      end else begin
        bus.out_valid <= 1'b0;
        if (bus.in_valid && hazard && bus.stall_cnt != '1)
          bus.stall_cnt <= bus.stall_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - directed vectors for the decode stage
module tb_id_stage_pipe;
  localparam int DATA_W = 32, FWD_DEPTH = 2, STALL_W = 16;
  localparam logic [31:0] INST_OR = 32'h00221825;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  id_stage_pipe_if #(.DATA_W(DATA_W), .FWD_DEPTH(FWD_DEPTH), .STALL_W(STALL_W)) bus ();

  id_stage_pipe #(.DATA_W(DATA_W), .FWD_DEPTH(FWD_DEPTH), .STALL_W(STALL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_fwd();
    bus.fwd_we = '0; bus.fwd_waddr = '0; bus.fwd_wdata = '0; bus.fwd_pend = '0;
  endtask

  task automatic set_fwd(input int i, input logic [4:0] a, input logic [31:0] d, input logic p);
    bus.fwd_we[i] = 1'b1;
    bus.fwd_waddr[5*i +: 5] = a;
    bus.fwd_wdata[32*i +: 32] = d;
    bus.fwd_pend[i] = p;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] inst);
    bus.in_valid = 1'b1; bus.in_pc = pc; bus.in_inst = inst;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0;
    bus.rf_rdata1 = '0; bus.rf_rdata2 = '0; bus.out_ready = 1'b1;
    clear_fwd();
    repeat (3) @(negedge clk);
    check("rst_valid", bus.out_valid, 0);
    check("rst_aluop", bus.out_aluop, 8'h00);
    check("rst_alusel", bus.out_alusel, 3'd0);
    check("rst_src2", bus.out_src2, 0);
    check("rst_stall", bus.stall_cnt, 0);
    rst = 1'b1;

    // T1: ori $1,$0,0x1100 - $0 ignores rf data
    present(32'h100, 32'h34011100); bus.rf_rdata1 = 32'hDEAD;
    #1;
    check("t1_in_ready", bus.in_ready, 1);
    check("t1_re1", bus.rf_re1, 1);
    check("t1_re2", bus.rf_re2, 0);
    check("t1_raddr1", bus.rf_raddr1, 0);
    step();
    check("t1_valid", bus.out_valid, 1);
    check("t1_pc", bus.out_pc, 32'h100);
    check("t1_aluop", bus.out_aluop, 8'h25);
    check("t1_alusel", bus.out_alusel, 3'd1);
    check("t1_src1", bus.out_src1, 0);
    check("t1_src2", bus.out_src2, 32'h1100);
    check("t1_wd", bus.out_wd, 1);
    check("t1_wreg", bus.out_wreg, 1);
    check("t1_invalid", bus.out_invalid, 0);

    // T2: nearest source wins; farther source used when only it matches
    present(32'h104, INST_OR); bus.rf_rdata1 = 32'h11; bus.rf_rdata2 = 32'h77;
    set_fwd(0, 5'd1, 32'hAAAA, 1'b0); set_fwd(1, 5'd1, 32'hBBBB, 1'b0);
    step();
    check("t2a_src1", bus.out_src1, 32'hAAAA);
    check("t2a_src2", bus.out_src2, 32'h77);
    present(32'h108, INST_OR); clear_fwd();
    set_fwd(0, 5'd1, 32'hAAAA, 1'b0); set_fwd(1, 5'd2, 32'h5, 1'b0);
    step();
    check("t2b_src1", bus.out_src1, 32'hAAAA);
    check("t2b_src2", bus.out_src2, 32'h5);
    check("t2b_wd", bus.out_wd, 3);
    check("t2b_aluop", bus.out_aluop, 8'h25);

    // T3: fwd0 $1 pending two cycles
    present(32'h10C, INST_OR); clear_fwd();
    set_fwd(0, 5'd1, 32'h0, 1'b1); set_fwd(1, 5'd2, 32'h5, 1'b0);
    #1;
    check("t3_in_ready", bus.in_ready, 0);
    for (int k = 1; k <= 2; k++) begin
      step();
      check("t3_bubble", bus.out_valid, 0);
      check("t3_stall", bus.stall_cnt, k);
      check("t3_hold_ready", bus.in_ready, 0);
    end
    bus.fwd_pend[0] = 1'b0; bus.fwd_wdata[31:0] = 32'hAAAA;
    #1;
    check("t3_release", bus.in_ready, 1);
    step();
    check("t3_valid", bus.out_valid, 1);
    check("t3_pc", bus.out_pc, 32'h10C);
    check("t3_src1", bus.out_src1, 32'hAAAA);
    check("t3_src2", bus.out_src2, 32'h5);
    check("t3_stall_end", bus.stall_cnt, 2);

    // Pending farther source shadowed by a ready nearer one
    present(32'h110, INST_OR); clear_fwd(); bus.rf_rdata1 = 32'h11;
    set_fwd(0, 5'd2, 32'h9, 1'b0); set_fwd(1, 5'd2, 32'h66, 1'b1);
    #1;
    check("shadow_ready", bus.in_ready, 1);
    step();
    check("shadow_src1", bus.out_src1, 32'h11);
    check("shadow_src2", bus.out_src2, 32'h9);
    check("shadow_stall", bus.stall_cnt, 2);

    // T4: sll $2,$1,4
    present(32'h114, 32'h00011100); clear_fwd(); bus.rf_rdata2 = 32'h3;
    #1;
    check("t4_re1", bus.rf_re1, 0);
    check("t4_raddr2", bus.rf_raddr2, 1);
    step();
    check("t4_src1", bus.out_src1, 4);
    check("t4_src2", bus.out_src2, 3);
    check("t4_alusel", bus.out_alusel, 3'd2);
    check("t4_aluop", bus.out_aluop, 8'h7C);
    check("t4_wd", bus.out_wd, 2);
    check("t4_wreg", bus.out_wreg, 1);

    // T5: backpressure with a hazard present must not count stalls
    bus.out_ready = 1'b0; present(32'h118, 32'h382500FF);
    set_fwd(0, 5'd1, 32'h0, 1'b1); bus.rf_rdata1 = 32'h10;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t5_in_ready", bus.in_ready, 0);
      step();
      check("t5_valid", bus.out_valid, 1);
      check("t5_pc", bus.out_pc, 32'h114);
      check("t5_src1", bus.out_src1, 4);
      check("t5_stall", bus.stall_cnt, 2);
    end
    clear_fwd(); bus.out_ready = 1'b1;
    #1;
    check("t5_release", bus.in_ready, 1);
    step();
    check("t5_xori_aluop", bus.out_aluop, 8'h26);
    check("t5_xori_src1", bus.out_src1, 32'h10);
    check("t5_xori_src2", bus.out_src2, 32'hFF);
    check("t5_xori_wd", bus.out_wd, 5);

    // T6: unknown opcode, then reset during a stall
    present(32'h11C, 32'hFC221825);
    #1;
    check("t6_re1", bus.rf_re1, 0);
    check("t6_re2", bus.rf_re2, 0);
    step();
    check("t6_valid", bus.out_valid, 1);
    check("t6_invalid", bus.out_invalid, 1);
    check("t6_wreg", bus.out_wreg, 0);
    check("t6_aluop", bus.out_aluop, 8'h00);
    present(32'h120, INST_OR); set_fwd(0, 5'd1, 32'h0, 1'b1);
    step();
    step();
    check("t6_stall", bus.stall_cnt, 4);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_stall", bus.stall_cnt, 0);
    check("t6_rst_valid", bus.out_valid, 0);
    @(negedge clk);
    rst = 1'b1;

    // Reset during backpressure drops the held bundle at once
    clear_fwd(); bus.rf_rdata1 = 32'h21; bus.rf_rdata2 = 32'h2;
    present(32'h124, INST_OR);
    step();
    check("bp_src1", bus.out_src1, 32'h21);
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    step();
    check("bp_hold", bus.out_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("bp_rst_valid", bus.out_valid, 0);
    check("bp_rst_src1", bus.out_src1, 0);
    check("bp_rst_pc", bus.out_pc, 0);
    check("bp_rst_wd", bus.out_wd, 0);
    @(negedge clk);
    rst = 1'b1; bus.out_ready = 1'b1;
    step();
    check("idle_valid", bus.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
